sdr_write_combiner: RTL and testbench
=====================================

SDR_WRITE_COMBINER -- requirements
Module: sdr_write_combiner

Interface
REQ-001 SHALL have port: clk  in  1  single clock for all logic.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: in_valid  in  1  byte write offered by the loader.
REQ-004 SHALL have port: in_addr  in  25  SDRAM byte address of the byte.
REQ-005 SHALL have port: in_data  in  8  byte value.
REQ-006 SHALL have port: in_ready  out  1  byte accepted when in_valid & in_ready at a clk edge.
REQ-007 SHALL have port: flush  in  1  single-cycle pulse; forces any pending half-word out (end of region).
REQ-008 SHALL have port: sdr_addr  out  25  word byte address, bit0 always 0.
REQ-009 SHALL have port: sdr_data  out  16  {odd byte, even byte}.
REQ-010 SHALL have port: sdr_be  out  2  lane enables; [0] = even byte, [1] = odd byte.
REQ-011 SHALL have port: sdr_req  out  1  level request, held until acknowledged.
REQ-012 SHALL have port: sdr_rdy  in  1  one-cycle acknowledge from the SDRAM controller.
REQ-013 SHALL have port: idle  out  1  high when nothing is pending, queued or requested.
REQ-014 SHALL have parameter: DEPTH, default SDR_WB_DEPTH (4), word-FIFO depth (power of two).

Function
REQ-015 SHALL hold at most one pending half-word: {addr[24:1], data, be}.
REQ-016 SHALL handle an accepted even byte as follows: if a half-word is pending, push it to the FIFO; start a new pending half-word with be=01.
REQ-017 SHALL handle an accepted odd byte whose addr[24:1] matches the pending half-word as follows: merge it into the high lane, push with be=11, and clear pending.
REQ-018 SHALL handle an accepted odd byte with no pending half-word by pushing it immediately with be=10.
REQ-019 SHALL handle an odd byte with a mismatching pending half-word as follows: in_ready=0 that cycle, push the pending half-word and clear pending; the byte is accepted on the next cycle per REQ-018.
REQ-020 SHALL drive in_ready = FIFO not full & ~(mismatch condition of REQ-019) & ~(flush with pending).
REQ-021 SHALL, on flush, push the pending half-word if present, and do nothing otherwise; flush takes priority over in_valid in the same cycle.
REQ-022 SHALL replicate the enabled byte into any disabled lane of sdr_data.
REQ-023 SHALL perform at most one FIFO push per cycle, and SHALL never push when the FIFO is full.
REQ-024 SHALL implement an issue FSM with state IDLE: if the FIFO is non-empty, pop the head into the sdr_* registers, set sdr_req=1, and go to REQ.
REQ-025 SHALL implement FSM state REQ: hold the sdr_* outputs stable; on sdr_rdy=1, clear sdr_req and go to IDLE.
REQ-026 SHALL provide request latency: a word pushed at edge E raises sdr_req at edge E+1 when the FSM is IDLE and the FIFO was empty.
REQ-027 SHALL leave at least one cycle with sdr_req low between consecutive requests.
REQ-028 SHALL ignore sdr_rdy while in IDLE.
REQ-029 SHALL allow a push and a pop in the same cycle; the FIFO count is then unchanged, including at full.
REQ-030 SHALL drive idle = FIFO empty & no pending half-word & state IDLE.

Reset
REQ-031 SHALL, on reset, clear the FIFO and the pending half-word, set the state to IDLE, drive sdr_req=0, sdr_addr=0, sdr_data=0, sdr_be=0, in_ready=0 for the reset cycle, and idle=1 after reset.
REQ-032 SHALL, on reset mid-request, drop sdr_req in the same edge and discard all queued data; a later sdr_rdy is ignored.

Structure
REQ-033 SHALL place SDR_WB_DEPTH and the typedef sdr_wb_word_t {addr[24:1], data[15:0], be[1:0]} in m107_pkg.
REQ-034 SHALL implement the word FIFO as one sub-module, sync_fifo (parameterised width/depth, synchronous reset, full/empty/count).

Verification
REQ-035 SHALL verify: bytes 0xAA@0x100 then 0xBB@0x101 -> one request addr 0x100, data 0xBBAA, be 11.
REQ-036 SHALL verify: 0x11@0x200 then flush -> addr 0x200, data 0x1111, be 01; idle=1 after ack.
REQ-037 SHALL verify: 0x22@0x300 then 0x33@0x305 -> in_ready low one cycle; requests (0x300, 0x2222, 01) then (0x304, 0x3333, 10).
REQ-038 SHALL verify: 12 sequential bytes from 0x0 with sdr_rdy withheld -> in_ready drops once 4 words are queued plus one in REQ; after acks resume, 6 words 0x0..0xA are issued in order with no loss.
REQ-039 SHALL verify: reset asserted while sdr_req=1 with 3 queued words -> next edge sdr_req=0, idle=1; a late sdr_rdy produces no request.

Source files
------------

// File: rtl/sdr_write_combiner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : m107_pkg
// Purpose  : Shared types and constants for the SDRAM write combiner.
//            sdr_wb_word_t is one half-word write: word address (addr[24:1]),
//            16-bit data {odd byte, even byte} and the two lane enables.
// Revision : 1.0 - initial release
// ============================================================================
package m107_pkg;

   localparam int SDR_WB_DEPTH = 4;

   typedef struct packed {
      logic [23:0] addr;
      logic [15:0] data;
      logic [1:0]  be;
   } sdr_wb_word_t;

   // Build a word with the enabled byte copied into any disabled lane, so
   // the data bus never carries stale bytes.
   function automatic sdr_wb_word_t mk_word(input logic [23:0] waddr,
                                            input logic [7:0]  even_b,
                                            input logic [7:0]  odd_b,
                                            input logic [1:0]  be);
      sdr_wb_word_t w;
      w.addr       = waddr;
      w.be         = be;
      w.data[7:0]  = be[0] ? even_b : odd_b;
      w.data[15:8] = be[1] ? odd_b  : even_b;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sdr_write_combiner_if.sv
`default_nettype none
// ============================================================================
// Module   : sdr_write_combiner_if
// Purpose  : Bundles the byte-loader side and the SDRAM-controller side of
//            the write combiner.
//   Loader     : in_valid, in_addr[24:0], in_data[7:0], in_ready, flush
//   Controller : sdr_addr[24:0], sdr_data[15:0], sdr_be[1:0], sdr_req, sdr_rdy
//   Status     : idle
//   slave  modport = the combiner, master modport = its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface sdr_write_combiner_if;
   logic        in_valid;
   logic [24:0] in_addr;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        flush;
   logic [24:0] sdr_addr;
   logic [15:0] sdr_data;
   logic [1:0]  sdr_be;
   logic        sdr_req;
   logic        sdr_rdy;
   logic        idle;

   modport slave (
      input  in_valid, in_addr, in_data, flush, sdr_rdy,
      output in_ready, sdr_addr, sdr_data, sdr_be, sdr_req, idle
   );

   modport master (
      output in_valid, in_addr, in_data, flush, sdr_rdy,
      input  in_ready, sdr_addr, sdr_data, sdr_be, sdr_req, idle
   );
endinterface
`default_nettype wire

// File: rtl/sdr_write_combiner_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with synchronous reset. Push and pop in the
//            same cycle are allowed, including while full.
//   clk, reset        : clock, synchronous active-high reset
//   push, push_data   : write request / data
//   pop, pop_data     : read request / head of queue (valid when !empty)
//   full, empty, count: occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4          // power of two, >= 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q,  count_d;
   logic             do_push, do_pop;

   assign full     = (count_q == (AW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so a push at full is legal then.
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push & ~do_pop)      count_d = count_q + 1'b1;
      else if (do_pop & ~do_push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: contents are only read behind the count.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/sdr_write_combiner.sv
`default_nettype none
// ============================================================================
// Module   : sdr_write_combiner
// Purpose  : Merges a byte stream from a loader into 16-bit SDRAM writes with
//            lane enables, queues them in a small FIFO and issues them one at
//            a time with a level req / pulse ack handshake.
//   clk   : single clock
//   reset : synchronous, active-high
//   bus   : sdr_write_combiner_if.slave (loader, controller and idle status)
//   DEPTH : word-FIFO depth (power of two)
// Revision : 1.0 - initial release
// ============================================================================
module sdr_write_combiner
   import m107_pkg::*;
#(
   parameter int DEPTH = SDR_WB_DEPTH
) (
   input  logic                clk,
   input  logic                reset,
   sdr_write_combiner_if.slave bus
);
   localparam logic [0:0] c_ST_IDLE = 1'b0;
   localparam logic [0:0] c_ST_REQ  = 1'b1;

   // Pending half-word: only ever an even byte waiting for its odd partner.
   logic         pend_valid_q, pend_valid_d;
   logic [23:0]  pend_addr_q,  pend_addr_d;
   logic [7:0]   pend_byte_q,  pend_byte_d;
   // Remembers a flush that arrived while the FIFO was full.
   logic         flush_hold_q, flush_hold_d;

   logic [0:0]   state_q, state_d;
   sdr_wb_word_t out_q,   out_d;
   logic         req_q,   req_d;

   logic              push, pop;
   sdr_wb_word_t      push_word, head_word;
   logic              fifo_full, fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;

   logic         flush_act, flush_pend, word_match, mismatch, in_ready, accept;
   sdr_wb_word_t pend_word;

   sync_fifo #(
      .WIDTH ($bits(sdr_wb_word_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_word),
      .pop       (pop),
      .pop_data  (head_word),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign flush_act  = bus.flush | flush_hold_q;
   assign flush_pend = flush_act & pend_valid_q;
   assign word_match = (bus.in_addr[24:1] == pend_addr_q);
   // An odd byte for a different word must first evict the pending one.
   assign mismatch   = bus.in_valid & bus.in_addr[0] & pend_valid_q & ~word_match;
   assign in_ready   = ~reset & ~fifo_full & ~mismatch & ~flush_pend;
   assign accept     = bus.in_valid & in_ready;
   assign pend_word  = mk_word(pend_addr_q, pend_byte_q, 8'h00, 2'b01);

   // Combining path: decides the (single) FIFO push for this cycle.
   always_comb begin
      push         = 1'b0;
      push_word    = pend_word;
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      pend_byte_d  = pend_byte_q;
      flush_hold_d = flush_hold_q;

      if (flush_pend) begin
         if (~fifo_full) begin
            push         = 1'b1;
            pend_valid_d = 1'b0;
            flush_hold_d = 1'b0;
         end else begin
            flush_hold_d = 1'b1;
         end
      end else if (accept) begin
         if (~bus.in_addr[0]) begin
            push         = pend_valid_q;
            pend_valid_d = 1'b1;
            pend_addr_d  = bus.in_addr[24:1];
            pend_byte_d  = bus.in_data;
         end else if (pend_valid_q) begin
            push         = 1'b1;
            push_word    = mk_word(pend_addr_q, pend_byte_q, bus.in_data, 2'b11);
            pend_valid_d = 1'b0;
         end else begin
            push         = 1'b1;
            push_word    = mk_word(bus.in_addr[24:1], 8'h00, bus.in_data, 2'b10);
         end
      end else if (mismatch & ~fifo_full) begin
         push         = 1'b1;
         pend_valid_d = 1'b0;
      end
   end

   // Issue FSM: one request in flight; returning to IDLE after each ack
   // guarantees a low cycle on sdr_req between requests.
   always_comb begin
      pop     = 1'b0;
      state_d = state_q;
      out_d   = out_q;
      req_d   = req_q;
      case (state_q)
         c_ST_IDLE: begin
            if (~fifo_empty) begin
               pop     = 1'b1;
               out_d   = head_word;
               req_d   = 1'b1;
               state_d = c_ST_REQ;
            end
         end
         c_ST_REQ: begin
            if (bus.sdr_rdy) begin
               req_d   = 1'b0;
               state_d = c_ST_IDLE;
            end
         end
         default: begin
            req_d   = 1'b0;
            state_d = c_ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_byte_q  <= '0;
         flush_hold_q <= 1'b0;
         state_q      <= c_ST_IDLE;
         out_q        <= '0;
         req_q        <= 1'b0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         pend_byte_q  <= pend_byte_d;
         flush_hold_q <= flush_hold_d;
         state_q      <= state_d;
         out_q        <= out_d;
         req_q        <= req_d;
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.sdr_addr = {out_q.addr, 1'b0};
   assign bus.sdr_data = out_q.data;
   assign bus.sdr_be   = out_q.be;
   assign bus.sdr_req  = req_q;
   assign bus.idle     = (fifo_count == '0) & ~pend_valid_q & (state_q == c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sdr_write_combiner.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdr_write_combiner
// Purpose  : Self-checking bench for sdr_write_combiner: directed scenarios
//            followed by randomized byte traffic scored against a
//            transaction-level model of the combining rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdr_write_combiner;

   typedef struct {
      logic [24:0] addr;
      logic [15:0] data;
      logic [1:0]  be;
   } wr_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sdr_write_combiner_if bus ();

   sdr_write_combiner #(.DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   n_vec  = 0;
   int   n_fail = 0;
   wr_t  exp_q[$];
   wr_t  got_q[$];
   wr_t  cur;

   // model state: an even byte waiting for its partner
   bit          m_pend;
   logic [24:0] m_addr;
   logic [7:0]  m_byte;

   bit          ack_en;
   int          ack_pct;
   logic        req_prev;
   bit          acc_s, fl_s, ack_s;
   logic [24:0] a_addr;
   logic [7:0]  a_data;
   int          accepted = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic emit(input logic [24:0] addr, input logic [7:0] lo, input logic [7:0] hi,
                       input logic [1:0] be);
      wr_t w;
      w.addr = {addr[24:1], 1'b0};
      w.be   = be;
      case (be)
         2'b01:   w.data = {lo, lo};
         2'b10:   w.data = {hi, hi};
         default: w.data = {hi, lo};
      endcase
      exp_q.push_back(w);
   endtask

   task automatic model_byte(input logic [24:0] addr, input logic [7:0] data);
      if (addr[0] == 1'b0) begin
         if (m_pend) emit(m_addr, m_byte, 8'h00, 2'b01);
         m_pend = 1;
         m_addr = addr;
         m_byte = data;
      end else if (m_pend && (addr >> 1) == (m_addr >> 1)) begin
         emit(m_addr, m_byte, data, 2'b11);
         m_pend = 0;
      end else begin
         if (m_pend) emit(m_addr, m_byte, 8'h00, 2'b01);
         m_pend = 0;
         emit(addr, 8'h00, data, 2'b10);
      end
   endtask

   // One clock: sample at the falling edge, act after the rising edge.
   task automatic cycle();
      @(negedge clk);
      acc_s  = bus.in_valid && bus.in_ready;
      fl_s   = bus.flush;
      ack_s  = bus.sdr_rdy && bus.sdr_req;
      a_addr = bus.in_addr;
      a_data = bus.in_data;
      @(posedge clk);
      #1;
      if (fl_s && m_pend) begin
         emit(m_addr, m_byte, 8'h00, 2'b01);
         m_pend = 0;
      end else if (acc_s) begin
         accepted++;
         model_byte(a_addr, a_data);
      end
      if (ack_s) check("req_drop_after_ack", bus.sdr_req, 0);
      if (bus.sdr_req) begin
         if (!req_prev) begin
            cur.addr = bus.sdr_addr;
            cur.data = bus.sdr_data;
            cur.be   = bus.sdr_be;
            got_q.push_back(cur);
         end else if (!ack_s) begin
            check("hold_addr", bus.sdr_addr, cur.addr);
            check("hold_data", bus.sdr_data, cur.data);
            check("hold_be",   bus.sdr_be,   cur.be);
         end
      end
      req_prev    = bus.sdr_req;
      bus.sdr_rdy = ack_en && bus.sdr_req && ($urandom_range(0, 99) < ack_pct);
   endtask

   task automatic send(input logic [24:0] a, input logic [7:0] d, input int max,
                       output int stalls, output bit ok);
      bus.in_valid = 1'b1;
      bus.in_addr  = a;
      bus.in_data  = d;
      stalls = 0;
      ok     = 0;
      for (int i = 0; i < max; i++) begin
         cycle();
         if (acc_s) begin
            ok = 1;
            break;
         end
         stalls++;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic pulse_flush();
      bus.flush = 1'b1;
      cycle();
      bus.flush = 1'b0;
   endtask

   task automatic drain(input int max);
      ack_en  = 1;
      ack_pct = 100;
      for (int i = 0; i < max; i++) begin
         cycle();
         if (bus.idle && !bus.sdr_req) break;
      end
      check("drain_idle", bus.idle, 1);
   endtask

   task automatic check_word(input string tag, input int idx, input logic [24:0] addr,
                             input logic [15:0] data, input logic [1:0] be);
      wr_t w;
      w.addr = 'x; w.data = 'x; w.be = 'x;
      if (idx < got_q.size()) w = got_q[idx];
      check({tag, "_addr"}, w.addr, addr);
      check({tag, "_data"}, w.data, data);
      check({tag, "_be"},   w.be,   be);
   endtask

   task automatic compare_sb(input string tag);
      int n;
      check({tag, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_addr"}, got_q[i].addr, exp_q[i].addr);
         check({tag, "_data"}, got_q[i].data, exp_q[i].data);
         check({tag, "_be"},   got_q[i].be,   exp_q[i].be);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          st, acc0, gsz;
      bit          ok;
      logic [24:0] ra;

      reset        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_addr  = '0;
      bus.in_data  = '0;
      bus.flush    = 1'b0;
      bus.sdr_rdy  = 1'b0;
      ack_en       = 0;
      ack_pct      = 0;
      req_prev     = 1'b0;
      m_pend       = 0;

      // ---- reset state ----
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_sdr_req",  bus.sdr_req,  0);
      check("rst_sdr_addr", bus.sdr_addr, 0);
      check("rst_sdr_data", bus.sdr_data, 0);
      check("rst_sdr_be",   bus.sdr_be,   0);
      @(posedge clk);
      #1;
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      check("rst_idle", bus.idle, 1);

      // ---- even + odd byte merge into one word ----
      ack_en = 1; ack_pct = 100;
      send(25'h100, 8'hAA, 20, st, ok);
      send(25'h101, 8'hBB, 20, st, ok);
      drain(50);
      check("merge_nreq", got_q.size(), 1);
      check_word("merge", 0, 25'h100, 16'hBBAA, 2'b11);
      compare_sb("merge_sb");

      // ---- lone even byte forced out by flush ----
      send(25'h200, 8'h11, 20, st, ok);
      pulse_flush();
      drain(50);
      check_word("flush", 0, 25'h200, 16'h1111, 2'b01);
      check("flush_idle", bus.idle, 1);
      compare_sb("flush_sb");

      // ---- odd byte for a different word evicts the pending one ----
      send(25'h300, 8'h22, 20, st, ok);
      send(25'h305, 8'h33, 20, st, ok);
      check("mismatch_stalls", st, 1);
      drain(50);
      check_word("mismatch0", 0, 25'h300, 16'h2222, 2'b01);
      check_word("mismatch1", 1, 25'h304, 16'h3333, 2'b10);
      compare_sb("mismatch_sb");

      // ---- back-pressure: FIFO full plus one word in REQ ----
      ack_en = 0;
      acc0 = accepted;
      for (int i = 0; i < 10; i++) send(25'(i), 8'(8'h40 + i), 8, st, ok);
      send(25'd10, 8'h4A, 8, st, ok);
      check("full_stall_ok",   ok, 0);
      check("full_in_ready",   bus.in_ready, 0);
      check("full_accepted",   accepted - acc0, 10);
      check("full_req_held",   bus.sdr_req, 1);
      ack_en = 1; ack_pct = 100;
      send(25'd10, 8'h4A, 40, st, ok);
      send(25'd11, 8'h4B, 40, st, ok);
      drain(100);
      check("full_nreq", got_q.size(), 6);
      for (int k = 0; k < 6; k++)
         check_word("full_word", k, 25'(2 * k), {8'(8'h41 + 2 * k), 8'(8'h40 + 2 * k)}, 2'b11);
      compare_sb("full_sb");

      // ---- reset in the middle of a request ----
      ack_en = 0;
      for (int i = 0; i < 8; i++) send(25'h400 + 25'(i), 8'(i), 8, st, ok);
      repeat (3) cycle();
      check("midrst_req_before", bus.sdr_req, 1);
      reset = 1'b1;
      cycle();
      check("midrst_req_after",  bus.sdr_req, 0);
      check("midrst_idle",       bus.idle, 1);
      reset = 1'b0;
      got_q.delete();
      exp_q.delete();
      m_pend = 0;
      gsz = got_q.size();
      bus.sdr_rdy = 1'b1;
      cycle();
      repeat (10) cycle();
      check("late_ack_nreq", got_q.size(), gsz);
      check("late_ack_req",  bus.sdr_req, 0);
      check("late_ack_idle", bus.idle, 1);

      // ---- randomized traffic against the model ----
      ack_en = 1; ack_pct = 40;
      ra = 25'($urandom);
      for (int n = 0; n < 300; n++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 6) begin
            pulse_flush();
         end else if (r < 14) begin
            cycle();
         end else begin
            r = $urandom_range(0, 99);
            if (r < 65)      ra = ra + 25'd1;
            else if (r < 80) ra = ra + 25'd2;
            else if (r < 88) ra = ra ^ 25'd1;
            else             ra = 25'($urandom);
            send(ra, 8'($urandom), 200, st, ok);
            check("rand_accept", ok, 1);
         end
      end
      pulse_flush();
      drain(500);
      compare_sb("rand_sb");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
